instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 52 +++++
 rtl/instr_encoder.sv | 209 ++++++++++++++++++++
 tb/tb_instr_encoder.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request/response bundle for instr_encoder.
// Ports: request fields + handshake, encoded FIFO head, error, pop count.
interface instr_encoder_if;
  logic        i_req_vld;
  logic        o_req_rdy;
  logic [4:0]  i_opc;
  logic [3:0]  i_alu_op;
  logic [2:0]  i_funct3;
  logic [4:0]  i_rd;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [31:0] i_imm;
  logic [31:0] o_instr;
  logic        o_instr_vld;
  logic        i_instr_rdy;
  logic        o_err;
  logic [15:0] o_cnt;

  modport master (
    output i_req_vld,
    output i_opc,
    output i_alu_op,
    output i_funct3,
    output i_rd,
    output i_rs1,
    output i_rs2,
    output i_imm,
    output i_instr_rdy,
    input  o_req_rdy,
    input  o_instr,
    input  o_instr_vld,
    input  o_err,
    input  o_cnt
  );

  modport slave (
    input  i_req_vld,
    input  i_opc,
    input  i_alu_op,
    input  i_funct3,
    input  i_rd,
    input  i_rs1,
    input  i_rs2,
    input  i_imm,
    input  i_instr_rdy,
    output o_req_rdy,
    output o_instr,
    output o_instr_vld,
    output o_err,
    output o_cnt
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: RV32I field encoder feeding a DEPTH-entry output FIFO.
// Ports: i_clk, i_rst_n (sync, active-low), bus (instr_encoder_if.slave).
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  instr_encoder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);

  localparam logic [4:0] OPC_R     = 5'b01100;
  localparam logic [4:0] OPC_I     = 5'b00100;
  localparam logic [4:0] OPC_S     = 5'b01000;
  localparam logic [4:0] OPC_L     = 5'b00000;
  localparam logic [4:0] OPC_B     = 5'b11000;
  localparam logic [4:0] OPC_LUI   = 5'b01101;
  localparam logic [4:0] OPC_AUIPC = 5'b00101;
  localparam logic [4:0] OPC_JAL   = 5'b11011;
  localparam logic [4:0] OPC_JALR  = 5'b11001;

  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLL = 4'd2;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;

  function automatic logic [2:0] alu_f3(
    input logic [3:0] op
  );
    case (op)
      4'd0, 4'd1: alu_f3 = 3'b000;
      4'd2:       alu_f3 = 3'b001;
      4'd3:       alu_f3 = 3'b010;
      4'd4:       alu_f3 = 3'b011;
      4'd5:       alu_f3 = 3'b100;
      4'd6, 4'd7: alu_f3 = 3'b101;
      4'd8:       alu_f3 = 3'b110;
      default:    alu_f3 = 3'b111;
    endcase
  endfunction

  logic [31:0] imm;
  logic [6:0]  opc7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [3:0]  aop;
  logic [2:0]  af3;
  logic [6:0]  af7;
  logic        fit12;
  logic        fitb;
  logic        fitj;
  logic        is_shift;
  logic        aop_bad;

  assign imm  = bus.i_imm;
  assign opc7 = {bus.i_opc, 2'b11};
  assign rd   = bus.i_rd;
  assign rs1  = bus.i_rs1;
  assign rs2  = bus.i_rs2;
  assign f3   = bus.i_funct3;
  assign aop  = bus.i_alu_op;
  assign af3  = alu_f3(aop);

  // Signed range tests: value fits when all bits above the
  // field's sign bit equal it.
  assign fit12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fitb  = (&imm[31:12]) | ~(|imm[31:12]);
  assign fitj  = (&imm[31:20]) | ~(|imm[31:20]);

  assign is_shift = (aop == ALU_SLL) |
                    (aop == ALU_SRL) |
                    (aop == ALU_SRA);
  assign aop_bad  = (aop > 4'd9);

  always_comb begin
    af7 = 7'b0000000;
    if (aop == ALU_SUB || aop == ALU_SRA)
      af7 = 7'b0100000;
  end

  logic [31:0] enc;
  logic        ill;

  always_comb begin
    enc = '0;
    ill = 1'b0;
    case (bus.i_opc)
      OPC_R: begin
        enc = {af7, rs2, rs1, af3, rd, opc7};
        ill = aop_bad;
      end
      OPC_I: begin
        if (is_shift) begin
          enc = {af7, imm[4:0], rs1, af3, rd, opc7};
          ill = |imm[31:5];
        end else begin
          enc = {imm[11:0], rs1, af3, rd, opc7};
          ill = ~fit12;
        end
        if (aop_bad || aop == ALU_SUB)
          ill = 1'b1;
      end
      OPC_L: begin
        enc = {imm[11:0], rs1, f3, rd, opc7};
        ill = ~fit12 | (f3 == 3'b011) |
              (f3 == 3'b110) | (f3 == 3'b111);
      end
      OPC_JALR: begin
        enc = {imm[11:0], rs1, 3'b000, rd, opc7};
        ill = ~fit12;
      end
      OPC_S: begin
        enc = {imm[11:5], rs2, rs1, f3,
               imm[4:0], opc7};
        ill = ~fit12 | (f3 > 3'b010);
      end
      OPC_B: begin
        enc = {imm[12], imm[10:5], rs2, rs1, f3,
               imm[4:1], imm[11], opc7};
        ill = ~fitb | imm[0] |
              (f3 == 3'b010) | (f3 == 3'b011);
      end
      OPC_JAL: begin
        enc = {imm[20], imm[10:1], imm[11],
               imm[19:12], rd, opc7};
        ill = ~fitj | imm[0];
      end
      OPC_LUI, OPC_AUIPC: begin
        enc = {imm[31:12], rd, opc7};
        ill = |imm[11:0];
      end
      default: begin
        enc = '0;
        ill = 1'b1;
      end
    endcase
  end

  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   num_q, num_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          full;
  logic          empty;
  logic          acc;
  logic          push;
  logic          pop;

  assign full  = (num_q == FULL_N);
  assign empty = (num_q == '0);
  // A full FIFO refuses requests even if the head pops this cycle.
  assign acc   = bus.i_req_vld & ~full;
  assign push  = acc & ~ill;
  assign pop   = ~empty & bus.i_instr_rdy;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    num_d  = num_q;
    cnt_d  = cnt_q;
    err_d  = acc & ill;
    if (push)
      wptr_d = wptr_q + 1'b1;
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
      cnt_d  = cnt_q + 16'd1;
    end
    unique case ({push, pop})
      2'b10:   num_d = num_q + 1'b1;
      2'b01:   num_d = num_q - 1'b1;
      default: num_d = num_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      num_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      num_q  <= num_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Storage needs no reset: occupancy gates what is visible.
  always_ff @(posedge i_clk) begin
    if (push)
      mem_q[wptr_q] <= enc;
  end

  assign bus.o_req_rdy   = ~full;
  assign bus.o_instr_vld = ~empty;
  assign bus.o_instr     = empty ? '0 : mem_q[rptr_q];
  assign bus.o_err       = err_q;
  assign bus.o_cnt       = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed + random checks of instr_encoder
// against a queue-based reference model.
module tb_instr_encoder;
  localparam int DEPTH = 4;

  localparam bit [4:0] R_ = 5'b01100;
  localparam bit [4:0] I_ = 5'b00100;
  localparam bit [4:0] S_ = 5'b01000;
  localparam bit [4:0] L_ = 5'b00000;
  localparam bit [4:0] B_ = 5'b11000;
  localparam bit [4:0] LU = 5'b01101;
  localparam bit [4:0] AU = 5'b00101;
  localparam bit [4:0] JL = 5'b11011;
  localparam bit [4:0] JR = 5'b11001;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;

  instr_encoder_if bus();

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;
  bit [31:0] q[$];
  int unsigned cnt_m = 0;
  bit err_m = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] ref_enc(
    input bit [4:0] opc, input bit [3:0] aop,
    input bit [2:0] f3, input bit [4:0] rd,
    input bit [4:0] rs1, input bit [4:0] rs2,
    input bit [31:0] imm, output bit ok);
    int s;
    int unsigned tab[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    bit [31:0] r, base, f7, fr3;
    bit sh;
    s = imm;
    r = 0;
    ok = 1;
    f7 = (aop == 1 || aop == 7) ? 32 : 0;
    fr3 = (aop <= 9) ? tab[aop] : 0;
    sh = (aop == 2 || aop == 6 || aop == 7);
    base = {opc, 2'b11};
    case (opc)
      R_: begin
        ok = aop <= 9;
        r = (f7 << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
          | (fr3 << 12) | (32'(rd) << 7) | base;
      end
      I_: begin
        ok = aop <= 9 && aop != 1;
        if (sh) begin
          ok = ok && s >= 0 && s <= 31;
          r = (f7 << 25) | ((imm & 31) << 20);
        end else begin
          ok = ok && s >= -2048 && s <= 2047;
          r = (imm & 32'hFFF) << 20;
        end
        r = r | (32'(rs1) << 15) | (fr3 << 12)
          | (32'(rd) << 7) | base;
      end
      L_, JR: begin
        ok = s >= -2048 && s <= 2047;
        if (opc == L_)
          ok = ok && f3 != 3 && f3 != 6 && f3 != 7;
        r = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15)
          | ((opc == L_) ? 32'(f3) << 12 : 0)
          | (32'(rd) << 7) | base;
      end
      S_: begin
        ok = f3 <= 2 && s >= -2048 && s <= 2047;
        r = (((imm >> 5) & 127) << 25) | (32'(rs2) << 20)
          | (32'(rs1) << 15) | (32'(f3) << 12)
          | ((imm & 31) << 7) | base;
      end
      B_: begin
        ok = f3 != 2 && f3 != 3 && s >= -4096 && s <= 4094
          && imm[0] == 0;
        r = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25)
          | (32'(rs2) << 20) | (32'(rs1) << 15)
          | (32'(f3) << 12) | (((imm >> 1) & 15) << 8)
          | (((imm >> 11) & 1) << 7) | base;
      end
      JL: begin
        ok = s >= -1048576 && s <= 1048574 && imm[0] == 0;
        r = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
          | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12)
          | (32'(rd) << 7) | base;
      end
      LU, AU: begin
        ok = (imm & 32'hFFF) == 0;
        r = (imm & 32'hFFFFF000) | (32'(rd) << 7) | base;
      end
      default: ok = 0;
    endcase
    return r;
  endfunction

  task automatic tick();
    bit ok, acc, pop;
    bit [31:0] e;
    if (!i_rst_n) begin
      q.delete();
      cnt_m = 0;
      err_m = 0;
    end else begin
      e = ref_enc(bus.i_opc, bus.i_alu_op, bus.i_funct3,
                  bus.i_rd, bus.i_rs1, bus.i_rs2, bus.i_imm, ok);
      acc = bus.i_req_vld && q.size() < DEPTH;
      pop = q.size() > 0 && bus.i_instr_rdy;
      if (pop) begin
        void'(q.pop_front());
        cnt_m = (cnt_m + 1) & 32'hFFFF;
      end
      if (acc && ok)
        q.push_back(e);
      err_m = acc && !ok;
    end
    @(posedge i_clk);
    #1;
    check("vld", 32'(bus.o_instr_vld), 32'(q.size() != 0));
    check("rdy", 32'(bus.o_req_rdy), 32'(q.size() < DEPTH));
    check("instr", bus.o_instr, (q.size() != 0) ? q[0] : 32'h0);
    check("err", 32'(bus.o_err), 32'(err_m));
    check("cnt", 32'(bus.o_cnt), cnt_m);
  endtask

  task automatic req(input bit [4:0] opc, input bit [3:0] aop,
                     input bit [2:0] f3, input bit [4:0] rd,
                     input bit [4:0] rs1, input bit [4:0] rs2,
                     input bit [31:0] imm);
    bus.i_req_vld = 1'b1;
    bus.i_opc = opc;
    bus.i_alu_op = aop;
    bus.i_funct3 = f3;
    bus.i_rd = rd;
    bus.i_rs1 = rs1;
    bus.i_rs2 = rs2;
    bus.i_imm = imm;
  endtask

  task automatic idle();
    bus.i_req_vld = 1'b0;
  endtask

  function automatic bit [31:0] rand_imm(input bit [4:0] opc,
                                         input bit [3:0] aop);
    int lo, hi, v;
    int unsigned sel;
    sel = $urandom_range(0, 3);
    lo = -2048;
    hi = 2047;
    if (opc == I_ && (aop == 2 || aop == 6 || aop == 7)) begin
      lo = 0; hi = 31;
    end else if (opc == B_) begin
      lo = -4096; hi = 4094;
    end else if (opc == JL) begin
      lo = -1048576; hi = 1048574;
    end
    if (opc == LU || opc == AU)
      return (sel == 0) ? $urandom : ($urandom & 32'hFFFFF000);
    case (sel)
      0: v = $urandom;
      1: begin
        case ($urandom_range(0, 3))
          0: v = lo - 1;
          1: v = lo;
          2: v = hi;
          default: v = hi + 1;
        endcase
      end
      default: v = int'($urandom_range(0, hi - lo + 4)) + lo - 2;
    endcase
    if (sel >= 2 && (opc == B_ || opc == JL) && $urandom_range(0, 3) != 0)
      v = v & ~1;
    return v;
  endfunction

  initial begin
    bit [4:0] opcs[9] = '{R_, I_, S_, L_, B_, LU, AU, JL, JR};
    bit [4:0] o;
    bit [3:0] a;
    bus.i_instr_rdy = 1'b0;
    req(0, 0, 0, 0, 0, 0, 0);
    idle();
    i_rst_n = 1'b0;
    tick();
    tick();
    check("rst_vld", 32'(bus.o_instr_vld), 32'd0);
    check("rst_rdy", 32'(bus.o_req_rdy), 32'd1);
    i_rst_n = 1'b1;

    req(R_, 0, 0, 3, 1, 2, 0);
    tick();
    idle();
    check("r_add", bus.o_instr, 32'h002081B3);
    bus.i_instr_rdy = 1'b1;
    req(I_, 0, 0, 1, 0, 0, 32'hFFFFFFFF);
    tick();
    check("i_add", bus.o_instr, 32'hFFF00093);
    req(I_, 7, 0, 5, 5, 0, 3);
    tick();
    check("i_sra", bus.o_instr, 32'h4032D293);
    req(S_, 0, 3'b010, 0, 1, 2, 8);
    tick();
    check("s_sw", bus.o_instr, 32'h0020A423);
    idle();
    tick();
    bus.i_instr_rdy = 1'b0;

    req(B_, 0, 0, 0, 1, 2, 3);
    tick();
    check("b_odd_err", 32'(bus.o_err), 32'd1);
    check("b_odd_vld", 32'(bus.o_instr_vld), 32'd0);
    idle();
    tick();
    check("b_odd_pulse", 32'(bus.o_err), 32'd0);

    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      req(LU, 0, 0, 5'(i), 0, 0, 32'(i) << 12);
      tick();
    end
    check("full_rdy", 32'(bus.o_req_rdy), 32'd0);
    check("full_head", bus.o_instr, 32'h000010B7);
    bus.i_instr_rdy = 1'b1;
    tick();
    tick();
    idle();
    for (int i = 0; i < 8; i++)
      tick();
    check("drain_cnt", 32'(bus.o_cnt), 32'd5);
    check("drain_vld", 32'(bus.o_instr_vld), 32'd0);

    bus.i_instr_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(JL, 0, 0, 5'(i), 0, 0, 32'(i * 16));
      tick();
    end
    req(B_, 0, 0, 0, 0, 0, 1);
    i_rst_n = 1'b0;
    tick();
    check("rst3_vld", 32'(bus.o_instr_vld), 32'd0);
    check("rst3_cnt", 32'(bus.o_cnt), 32'd0);
    check("rst3_err", 32'(bus.o_err), 32'd0);
    i_rst_n = 1'b1;
    idle();
    bus.i_instr_rdy = 1'b1;
    for (int i = 0; i < 4; i++)
      tick();

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0)
        o = 5'($urandom);
      else
        o = opcs[$urandom_range(0, 8)];
      if (o == R_ || o == I_)
        a = 4'($urandom_range(0, 11));
      else
        a = 4'($urandom_range(0, 9));
      req(o, a, 3'($urandom), 5'($urandom), 5'($urandom),
          5'($urandom), rand_imm(o, a));
      bus.i_req_vld = ($urandom_range(0, 3) != 0);
      bus.i_instr_rdy = ($urandom_range(0, 2) != 0);
      i_rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
